// File: rtl/mem_target_16b.sv
// Single-outstanding 16-bit LSU memory responder: accept, WAIT_STATES wait cycles, one-cycle mem_rdy.
// Latency accept->mem_rdy is 1+WAIT_STATES; the initiator holds mem_bus_assert, sampled only in IDLE.
module mem_target_16b #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        mem_bus_assert,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_cmd,
  input  logic        be0,
  input  logic        be1,
  input  logic        t_id,
  output logic        mem_rdy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_t_id
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [ADDR_BITS-1:0]   cap_idx;
  logic [15:0]            cap_data;
  logic                   cap_cmd;
  logic                   cap_be0;
  logic                   cap_be1;
  logic [15:0]            mem [DEPTH];

  // Address bit 0 and bits above the word index are don't-care, giving modulo-depth wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[15:ADDR_BITS+1], mem_addr[0]};

  function automatic logic [15:0] lane_mask(input logic [15:0] w, input logic b0, input logic b1);
    return {b1 ? w[15:8] : 8'h00, b0 ? w[7:0] : 8'h00};
  endfunction

  always_ff @(posedge clk) begin
    if (a_rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      mem_rdy  <= 1'b0;
      rd_valid <= 1'b0;
      rd_t_id  <= 1'b0;
      rd_data  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (mem_bus_assert) begin
            cap_idx  <= mem_addr[ADDR_BITS:1];
            cap_data <= mem_data;
            cap_cmd  <= mem_cmd;
            cap_be0  <= be0;
            cap_be1  <= be1;
            rd_t_id  <= t_id;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= WS_M1;
            end else begin
              state    <= RESP;
              mem_rdy  <= 1'b1;
              rd_valid <= ~mem_cmd;
              if (!mem_cmd)
                rd_data <= lane_mask(mem[mem_addr[ADDR_BITS:1]], be0, be1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state    <= RESP;
            mem_rdy  <= 1'b1;
            rd_valid <= ~cap_cmd;
            if (!cap_cmd)
              rd_data <= lane_mask(mem[cap_idx], cap_be0, cap_be1);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state    <= IDLE;
          mem_rdy  <= 1'b0;
          rd_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write commits on the edge that leaves RESP; a reset on that edge suppresses it.
  always_ff @(posedge clk) begin
    if (!a_rst && state == RESP && cap_cmd) begin
      if (cap_be0) mem[cap_idx][7:0]  <= cap_data[7:0];
      if (cap_be1) mem[cap_idx][15:8] <= cap_data[15:8];
    end
  end

endmodule

// File: tb/tb_mem_target_16b.sv
// Bench for mem_target_16b: four instances with different geometry/wait states, checked against a word-array model.
module tb_mem_target_16b;

  logic        clk = 1'b0;
  logic        a_rst;
  logic [3:0]  bus_a;
  logic [15:0] mem_addr, mem_data;
  logic        mem_cmd, be0, be1, t_id;
  wire  [3:0]  rdy, rvld, rtid;
  wire  [15:0] rdat [4];

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  int ab [4] = '{10, 10, 10, 4};
  int ws [4] = '{0, 3, 2, 0};
  logic [15:0] mdl [4][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_target_16b #(.ADDR_BITS(10), .WAIT_STATES(0)) u0 (.clk(clk), .a_rst(a_rst), .mem_bus_assert(bus_a[0]),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_cmd(mem_cmd), .be0(be0), .be1(be1), .t_id(t_id),
    .mem_rdy(rdy[0]), .rd_data(rdat[0]), .rd_valid(rvld[0]), .rd_t_id(rtid[0]));
  mem_target_16b #(.ADDR_BITS(10), .WAIT_STATES(3)) u1 (.clk(clk), .a_rst(a_rst), .mem_bus_assert(bus_a[1]),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_cmd(mem_cmd), .be0(be0), .be1(be1), .t_id(t_id),
    .mem_rdy(rdy[1]), .rd_data(rdat[1]), .rd_valid(rvld[1]), .rd_t_id(rtid[1]));
  mem_target_16b #(.ADDR_BITS(10), .WAIT_STATES(2)) u2 (.clk(clk), .a_rst(a_rst), .mem_bus_assert(bus_a[2]),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_cmd(mem_cmd), .be0(be0), .be1(be1), .t_id(t_id),
    .mem_rdy(rdy[2]), .rd_data(rdat[2]), .rd_valid(rvld[2]), .rd_t_id(rtid[2]));
  mem_target_16b #(.ADDR_BITS(4), .WAIT_STATES(0)) u3 (.clk(clk), .a_rst(a_rst), .mem_bus_assert(bus_a[3]),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_cmd(mem_cmd), .be0(be0), .be1(be1), .t_id(t_id),
    .mem_rdy(rdy[3]), .rd_data(rdat[3]), .rd_valid(rvld[3]), .rd_t_id(rtid[3]));

  // Reference model: plain word array per instance, index = byte address / 2 modulo depth.
  function automatic int widx(input int d, input logic [15:0] a);
    return (int'(a) >> 1) & ((1 << ab[d]) - 1);
  endfunction

  function automatic logic [15:0] model_rd(input int d, input logic [15:0] a, input logic b0, input logic b1);
    logic [15:0] w;
    w = mdl[d][widx(d, a)];
    return {b1 ? w[15:8] : 8'h00, b0 ? w[7:0] : 8'h00};
  endfunction

  task automatic model_wr(input int d, input logic [15:0] a, input logic [15:0] v, input logic b0, input logic b1);
    if (b0) mdl[d][widx(d, a)][7:0]  = v[7:0];
    if (b1) mdl[d][widx(d, a)][15:8] = v[15:8];
  endtask

  // Bus driver: enter and leave at #1 after a rising edge, in an IDLE cycle.
  task automatic xfer(input int d, input logic cmd, input logic [15:0] addr, input logic [15:0] data,
                      input logic b0, input logic b1, input logic tid, input bit scr,
                      output int lat, output logic [15:0] rd, output logic rv, output logic tid_ok,
                      output logic post);
    bus_a = 4'(1 << d); mem_cmd = cmd; mem_addr = addr; mem_data = data; be0 = b0; be1 = b1; t_id = tid;
    @(posedge clk); #1;
    lat = 1; tid_ok = 1'b1;
    while (rdy[d] !== 1'b1 && lat < 40) begin
      if (rtid[d] !== tid) tid_ok = 1'b0;
      if (scr) begin
        mem_addr = 16'($urandom); mem_data = 16'($urandom); mem_cmd = ~cmd;
        be0 = 1'($urandom); be1 = 1'($urandom); t_id = ~tid;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (rdy[d] !== 1'b1) lat = -1;
    if (rtid[d] !== tid) tid_ok = 1'b0;
    rd = rdat[d]; rv = rvld[d];
    bus_a = 4'b0;
    @(posedge clk); #1;
    post = rdy[d];
  endtask

  int          lat;
  logic [15:0] rd;
  logic        rv, tok, post;

  task automatic test_reset();
    a_rst = 1'b1; bus_a = 4'b0; mem_addr = 16'h0; mem_data = 16'h0;
    mem_cmd = 1'b0; be0 = 1'b0; be1 = 1'b0; t_id = 1'b0;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < 4; d++) begin
        n_asserts++;
        if ({rdy[d], rvld[d], rtid[d], rdat[d]} !== 19'h0) begin
          n_fail++;
          $display("FAIL reset_idle dut%0d cyc%0d: rdy=%b vld=%b tid=%b data=%h, required all 0", d, c, rdy[d], rvld[d], rtid[d], rdat[d]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_read();
    xfer(0, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b1, 1'b1, 0, lat, rd, rv, tok, post);
    model_wr(0, 16'h0010, 16'hBEEF, 1'b1, 1'b1);
    n_asserts++; if (lat !== 1) begin n_fail++; $display("FAIL wr_latency: got %0d, required 1", lat); end
    n_asserts++; if (tok !== 1'b1) begin n_fail++; $display("FAIL wr_tid: rd_t_id did not hold 1"); end
    n_asserts++; if (rv !== 1'b0) begin n_fail++; $display("FAIL wr_rd_valid: got %b, required 0", rv); end
    n_asserts++; if (post !== 1'b0) begin n_fail++; $display("FAIL wr_rdy_pulse: mem_rdy %b after RESP, required 0", post); end
    xfer(0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0, 0, lat, rd, rv, tok, post);
    n_asserts++; if (lat !== 1) begin n_fail++; $display("FAIL rd_latency: got %0d, required 1", lat); end
    n_asserts++; if (rv !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b, required 1", rv); end
    n_asserts++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h, required beef", rd); end
    n_asserts++; if (tok !== 1'b1) begin n_fail++; $display("FAIL rd_tid: rd_t_id did not hold 0"); end
  endtask

  task automatic test_byte_lanes();
    xfer(0, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b1, 1'b0, 0, lat, rd, rv, tok, post);
    model_wr(0, 16'h0020, 16'h1234, 1'b1, 1'b1);
    xfer(0, 1'b1, 16'h0020, 16'hAB00, 1'b0, 1'b1, 1'b1, 0, lat, rd, rv, tok, post);
    model_wr(0, 16'h0020, 16'hAB00, 1'b0, 1'b1);
    xfer(0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b0, 0, lat, rd, rv, tok, post);
    n_asserts++; if (rd !== model_rd(0, 16'h0020, 1'b1, 1'b1)) begin n_fail++; $display("FAIL lane_hi_write: got %h, required %h", rd, model_rd(0, 16'h0020, 1'b1, 1'b1)); end
    xfer(0, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 1'b1, 0, lat, rd, rv, tok, post);
    n_asserts++; if (rd !== model_rd(0, 16'h0020, 1'b1, 1'b0)) begin n_fail++; $display("FAIL lane0_read: got %h, required %h", rd, model_rd(0, 16'h0020, 1'b1, 1'b0)); end
    xfer(0, 1'b1, 16'h0020, 16'h5A5A, 1'b0, 1'b0, 1'b0, 0, lat, rd, rv, tok, post);
    n_asserts++; if (lat !== 1) begin n_fail++; $display("FAIL no_lane_complete: latency %0d, required 1", lat); end
    xfer(0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b0, 0, lat, rd, rv, tok, post);
    n_asserts++; if (rd !== model_rd(0, 16'h0020, 1'b1, 1'b1)) begin n_fail++; $display("FAIL no_lane_write: got %h, required %h", rd, model_rd(0, 16'h0020, 1'b1, 1'b1)); end
  endtask

  task automatic test_wait_states();
    logic [15:0] v;
    v = 16'($urandom);
    xfer(1, 1'b1, 16'h0040, v, 1'b1, 1'b1, 1'b1, 1, lat, rd, rv, tok, post);
    model_wr(1, 16'h0040, v, 1'b1, 1'b1);
    n_asserts++; if (lat !== 1 + ws[1]) begin n_fail++; $display("FAIL ws_wr_latency: got %0d, required %0d", lat, 1 + ws[1]); end
    n_asserts++; if (tok !== 1'b1) begin n_fail++; $display("FAIL ws_wr_tid: rd_t_id not held through WAIT/RESP"); end
    xfer(1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b1, 1'b0, 1, lat, rd, rv, tok, post);
    n_asserts++; if (lat !== 1 + ws[1]) begin n_fail++; $display("FAIL ws_rd_latency: got %0d, required %0d", lat, 1 + ws[1]); end
    n_asserts++; if (post !== 1'b0) begin n_fail++; $display("FAIL ws_rdy_pulse: mem_rdy %b after RESP, required 0", post); end
    n_asserts++; if (rd !== model_rd(1, 16'h0040, 1'b1, 1'b1) || rv !== 1'b1) begin n_fail++; $display("FAIL ws_rd_data: got %h vld %b, required %h vld 1", rd, rv, model_rd(1, 16'h0040, 1'b1, 1'b1)); end
    n_asserts++; if (tok !== 1'b1) begin n_fail++; $display("FAIL ws_rd_tid: rd_t_id not held at 0"); end
  endtask

  task automatic test_back_to_back_wrap();
    int c0;
    c0 = cyc;
    xfer(3, 1'b1, 16'h0002, 16'h5555, 1'b1, 1'b1, 1'b0, 0, lat, rd, rv, tok, post);
    model_wr(3, 16'h0002, 16'h5555, 1'b1, 1'b1);
    xfer(3, 1'b1, 16'h0022, 16'h6666, 1'b1, 1'b1, 1'b1, 0, lat, rd, rv, tok, post);
    model_wr(3, 16'h0022, 16'h6666, 1'b1, 1'b1);
    xfer(3, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b1, 1'b0, 0, lat, rd, rv, tok, post);
    n_asserts++; if (rd !== model_rd(3, 16'h0002, 1'b1, 1'b1)) begin n_fail++; $display("FAIL wrap_alias: got %h, required %h", rd, model_rd(3, 16'h0002, 1'b1, 1'b1)); end
    n_asserts++; if (cyc - c0 !== 6) begin n_fail++; $display("FAIL b2b_cycles: got %0d, required 6", cyc - c0); end
  endtask

  task automatic test_random(input int d, input logic [15:0] mask, input int words, input int n);
    logic        cmd, b0, b1, tid;
    logic [15:0] a, v, exp_rd;
    int          c0;
    for (int k = 0; k < words; k++) begin
      v = 16'($urandom);
      xfer(d, 1'b1, 16'(k << 1), v, 1'b1, 1'b1, 1'b0, 0, lat, rd, rv, tok, post);
      model_wr(d, 16'(k << 1), v, 1'b1, 1'b1);
    end
    c0 = cyc;
    for (int i = 0; i < n; i++) begin
      cmd = 1'($urandom); b0 = 1'($urandom); b1 = 1'($urandom); tid = 1'($urandom);
      a = 16'($urandom) & mask; v = 16'($urandom);
      exp_rd = model_rd(d, a, b0, b1);
      xfer(d, cmd, a, v, b0, b1, tid, (ws[d] > 0), lat, rd, rv, tok, post);
      if (cmd) model_wr(d, a, v, b0, b1);
      n_asserts++;
      if (lat !== 1 + ws[d] || rv !== !cmd || tok !== 1'b1 || post !== 1'b0 || (!cmd && rd !== exp_rd)) begin
        n_fail++;
        $display("FAIL rand dut%0d #%0d cmd=%b a=%h: lat=%0d vld=%b tid_ok=%b post=%b data=%h, required lat=%0d vld=%b tid_ok=1 post=0 data=%h",
                 d, i, cmd, a, lat, rv, tok, post, rd, 1 + ws[d], !cmd, exp_rd);
      end
    end
    n_asserts++;
    if (cyc - c0 !== n * (2 + ws[d])) begin n_fail++; $display("FAIL rand_throughput dut%0d: %0d cycles, required %0d", d, cyc - c0, n * (2 + ws[d])); end
  endtask

  task automatic test_reset_mid();
    int seen;
    xfer(2, 1'b1, 16'h0004, 16'h1357, 1'b1, 1'b1, 1'b0, 0, lat, rd, rv, tok, post);
    model_wr(2, 16'h0004, 16'h1357, 1'b1, 1'b1);
    n_asserts++; if (lat !== 1 + ws[2]) begin n_fail++; $display("FAIL rst_pre_latency: got %0d, required %0d", lat, 1 + ws[2]); end
    bus_a = 4'b0100; mem_cmd = 1'b1; mem_addr = 16'h0004; mem_data = 16'hFFFF; be0 = 1'b1; be1 = 1'b1; t_id = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b1; bus_a = 4'b0;
    @(posedge clk); #1;
    a_rst = 1'b0;
    n_asserts++; if (rdy[2] !== 1'b0 || rtid[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: rdy=%b tid=%b, required 0 0", rdy[2], rtid[2]); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (rdy[2] === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_asserts++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_rdy: mem_rdy seen %0d times, required 0", seen); end
    xfer(2, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b1, 1'b0, 0, lat, rd, rv, tok, post);
    n_asserts++; if (rd !== model_rd(2, 16'h0004, 1'b1, 1'b1)) begin n_fail++; $display("FAIL rst_mid_commit: got %h, required %h", rd, model_rd(2, 16'h0004, 1'b1, 1'b1)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_back_to_back_wrap();
    test_random(0, 16'hF83F, 32, 60);
    test_random(3, 16'hFFFF, 16, 60);
    test_random(1, 16'hF80F, 8, 20);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_target_16b.md
# mem_target_16b

Memory-side responder for the 16-bit LSU bus. It accepts the single outstanding request the LSU holds on the bus, inserts a programmable number of wait states, and commits byte-enabled writes into an internal word array. For reads it returns the addressed word with the LSU's transaction id, closing each transfer with a one-cycle `mem_rdy`. It sits between the core's LSU and on-chip RAM, and doubles as the bench model for LSU verification.

## Interface
- `ADDR_BITS`, 10: log2 of array depth in 16-bit words.
- `WAIT_STATES`, 0: extra cycles inserted between accept and `mem_rdy`; range 0..15.
- `clk`  in  1  single clock, rising edge.
- `a_rst`  in  1  reset, synchronous, active-high.
- `mem_bus_assert`  in  1  request present; held high by the initiator until it sees `mem_rdy`.
- `mem_addr`  in  16  byte address.
- `mem_data`  in  16  write data; bits 7:0 form lane 0, bits 15:8 form lane 1.
- `mem_cmd`  in  1  1 = write, 0 = read.
- `be0`, `be1`  in  1 each  byte-lane enables for lane 0 and lane 1.
- `t_id`  in  1  transaction id.
- `mem_rdy`  out  1  transfer complete, one-cycle pulse.
- `rd_data`  out  16  read data, valid while `rd_valid` is high.
- `rd_valid`  out  1  read response strobe; coincident with `mem_rdy` on reads only.
- `rd_t_id`  out  1  id of the completing transfer; valid while `mem_rdy` is high.

## Operation
- Word index is `mem_addr[ADDR_BITS:1]`. Bit 0 and bits above `ADDR_BITS` are ignored, so addresses wrap modulo the array depth.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: if `mem_bus_assert` is high, capture address, data, cmd, `be0`, `be1` and `t_id` into internal registers. Then go to WAIT if `WAIT_STATES` > 0, otherwise go to RESP.
  - WAIT: a down-counter is loaded with `WAIT_STATES`-1 on accept. Go to RESP when the counter reaches 0.
  - RESP: `mem_rdy` = 1 for exactly one cycle, then return to IDLE.
- Bus inputs are sampled only in IDLE. Changes while in WAIT or RESP are ignored.
- Write:
  - At the clock edge ending RESP, lane 0 is written when the captured `be0` = 1, and lane 1 when the captured `be1` = 1.
  - With both enables clear, nothing is written, but the transfer still completes.
  - `rd_valid` stays 0.
- Read:
  - `rd_data` is loaded from the array at the captured index on the edge that enters RESP.
  - Lanes whose enable is clear read as 0x00.
  - `rd_valid` = `mem_rdy` = 1 in RESP.
- `rd_t_id` equals the captured `t_id` in every cycle of WAIT and RESP.
- Back-to-back transfers: if `mem_bus_assert` is high in the IDLE cycle right after RESP, that is a new request and is accepted. There are no dead cycles beyond the IDLE accept cycle.
- A read issued right after a write to the same word returns the newly written data.

## Timing
- Reset: state = IDLE and counter = 0. `mem_rdy`, `rd_valid` and `rd_t_id` are 0 and `rd_data` = 0x0000. Array contents are not cleared.
- Reset asserted in WAIT or RESP aborts the transfer: no `mem_rdy` and no write commit. The first cycle after reset is IDLE.
- Latency, with the accept in cycle A: `mem_rdy` is high in cycle A+1+`WAIT_STATES`.
  - `WAIT_STATES` = 0: one transfer every 2 cycles.
  - In general, throughput is one transfer per 2+`WAIT_STATES` cycles.
- All outputs are registered or decoded from state only. There is no combinational path from bus inputs to outputs.

## Test plan
- Reset/idle: `a_rst` high for 2 cycles, `mem_bus_assert` low -> `mem_rdy` = 0, `rd_valid` = 0, `rd_data` = 0x0000 for 10 cycles.
- Word write then read, `WAIT_STATES` = 0:
  - Write addr 0x0010, data 0xBEEF, `be0` = `be1` = 1, `t_id` = 1 -> `mem_rdy` in A+1 with `rd_t_id` = 1.
  - Then read 0x0010 -> `rd_valid` with `rd_data` = 0xBEEF.
- Byte lanes:
  - Preload 0x1234 at 0x0020.
  - Write 0xAB00 with `be1` only, then read with both enables -> 0xAB34.
  - Read with `be0` only -> 0x0034.
- Wait states, `WAIT_STATES` = 3: read accepted in cycle 5 -> `mem_rdy` high only in cycle 9; changing `mem_addr` in cycles 6-8 has no effect.
- Back-to-back and wrap, `ADDR_BITS` = 4:
  - Write 0x5555 at 0x0002, then immediately write 0x6666 at 0x0022, which aliases to word 1.
  - Read 0x0002 -> 0x6666; the three transfers complete in 6 cycles.
- Reset mid-transfer, `WAIT_STATES` = 2: write 0xFFFF to 0x0004 with reset in the first WAIT cycle -> no `mem_rdy`; a later read of 0x0004 returns the prior value.
